alu: RTL and testbench
======================

Name: alu

Overview:
- Single-cycle, accumulator-based, instruction-driven ALU: executes one 12-bit instruction per clock from an external fetch unit (program counter plus program memory).
- Emits result words through a valid-qualified output port.
- Stops permanently on a HALT instruction until reset.
- Used as the compute core behind a simple program-ROM fetch stage.

Parameters:
- data_width, 12, width of accumulator, register file entries and out_data; must be >= 8.
- instruction_width, 12, instruction word width; opcode in [instruction_width-1 -: 4], operand imm8 in [7:0]; must equal 12 for this ISA.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- instruction  input  instruction_width  instruction to execute this cycle; sampled at the rising edge.
- out_data  output  data_width  last emitted accumulator value.
- out_valid  output  1  out_data is new this cycle (one-cycle pulse).
- halt  output  1  processor halted; sticky until reset.

Behaviour:
- State: accumulator ACC (data_width), register file R0..R3 (data_width each), out_data, out_valid, halt; all registered.
- Reset (rst=1 at a rising edge): ACC=0, R0..R3=0, out_data=0, out_valid=0, halt=0. The instruction input is ignored during reset. Reset overrides everything, including an active halt and any mid-program state.
- Each rising edge with rst=0 and halt=0 executes exactly one instruction. Any result is visible the following cycle (latency 1).
- Decode: op=instruction[11:8], imm=instruction[7:0], r=imm[1:0], sh=imm[3:0]. Unused operand bits are ignored.
- 0x0 NOP: no change.
- 0x1 LDI: ACC = zero-extended imm.
- 0x2 LDH: ACC[11:8] = imm[3:0]; ACC[7:0] unchanged.
- 0x3 ADDI: ACC = ACC + imm.
- 0x4 SUBI: ACC = ACC - imm.
- 0x5 ANDI: ACC = ACC & imm (zero-extended).
- 0x6 ORI: ACC = ACC | imm.
- 0x7 XORI: ACC = ACC ^ imm.
- 0x8 SHL: ACC = ACC << sh, logical.
- 0x9 SHR: ACC = ACC >> sh, logical. For both shifts, sh >= data_width gives 0.
- 0xA ST: R[r] = ACC.
- 0xB LD: ACC = R[r].
- 0xC ADDR: ACC = ACC + R[r].
- 0xD SUBR: ACC = ACC - R[r].
- 0xE OUT: out_data = ACC (value before this edge); out_valid = 1 for exactly one cycle.
- 0xF HALT: out_data = ACC; out_valid = 1 for one cycle; halt = 1 in the same cycle and stays 1.
- Arithmetic is modulo 2^data_width: carries and borrows are discarded, with no flags. Examples: 0xFFF+1=0x000, 0x000-1=0xFFF.
- out_valid is 0 in every cycle following a non-OUT/HALT instruction. out_data holds its value between emissions.
- While halt=1: all instructions are ignored, ACC, registers and out_data are frozen, and out_valid=0 after the HALT pulse cycle.
- The consumer may treat (out_valid && halt) as end-of-program; this combination occurs exactly once per run.
- Back-to-back OUTs each produce a pulse carrying the current ACC.
- An instruction that writes ACC followed by OUT emits the updated value, with no hazard, because execution is single-cycle.

Test Plan:
- Reset then LDI 0x48 (0x148), OUT (0xE00) -> one cycle after OUT: out_valid=1, out_data=0x048; next cycle out_valid=0, out_data still 0x048.
- LDI 0xFF (0x1FF), LDH 0xA (0x20A), ADDI 1 (0x301), OUT -> out_data=0xB00. Then LDH 0xF (0x20F), LDI 0xFF, LDH 0xF, ADDI 1, OUT -> 0x000 (wrap). SUBI 1 (0x401), OUT -> 0xFFF.
- LDI 0x21, ST R2 (0xA02), LDI 0x10, ADDR R2 (0xC02), OUT -> 0x031. Then SUBR R2 (0xD02), OUT -> 0x010. Then LD R2 (0xB02), OUT -> 0x021.
- LDI 0x0F, SHL 4 (0x804), OUT -> 0x0F0. Then XORI 0xFF (0x7FF), OUT -> 0x00F. Then SHR 12 (0x90C), OUT -> 0x000.
- LDI 0x41, HALT (0xF00) -> next cycle out_valid=1, halt=1, out_data=0x041. Following OUT/LDI instructions: out_valid stays 0, out_data stays 0x041, halt stays 1.
- After halt, or mid-program after several LDI/ST operations, assert rst for 2 cycles -> all outputs 0 and registers cleared. LD R2, OUT -> 0x000; the program restarts normally.

Source files
------------

// File: rtl/alu.sv
// Single-cycle accumulator ALU. Executes one 12-bit instruction per clock.
// It emits the accumulator through a valid-qualified output port.
// HALT stops it until reset.
module alu #(
  parameter int unsigned data_width        = 12,
  parameter int unsigned instruction_width = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [instruction_width-1:0] instruction,
  output logic [data_width-1:0]        out_data,
  output logic                         out_valid,
  output logic                         halt
);

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpLdi  = 4'h1,
    OpLdh  = 4'h2,
    OpAddi = 4'h3,
    OpSubi = 4'h4,
    OpAndi = 4'h5,
    OpOri  = 4'h6,
    OpXori = 4'h7,
    OpShl  = 4'h8,
    OpShr  = 4'h9,
    OpSt   = 4'hA,
    OpLd   = 4'hB,
    OpAddr = 4'hC,
    OpSubr = 4'hD,
    OpOut  = 4'hE,
    OpHalt = 4'hF
  } op_e;

  // Bits [11:8] of the accumulator, truncated when data_width is narrower than 12.
  localparam logic [data_width-1:0] HiMask = data_width'(12'hF00);

  logic [data_width-1:0] acc_q, acc_d;
  logic [data_width-1:0] regs_q [4];
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  halt_q, halt_d;
  logic                  reg_we;

  op_e                   op;
  logic [7:0]            imm;
  logic [1:0]            r;
  logic [3:0]            sh;
  logic [data_width-1:0] imm_ext;
  logic [data_width-1:0] reg_rd;

  assign op      = op_e'(instruction[instruction_width-1 -: 4]);
  assign imm     = instruction[7:0];
  assign r       = imm[1:0];
  assign sh      = imm[3:0];
  assign imm_ext = data_width'(imm);
  assign reg_rd  = regs_q[r];

  // Next-state decode for one instruction. A halted core holds all state.
  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halt_d      = halt_q;
    reg_we      = 1'b0;
    if (!halt_q) begin
      unique case (op)
        OpNop:  ;
        OpLdi:  acc_d = imm_ext;
        OpLdh:  acc_d = (acc_q & ~HiMask) | data_width'({imm[3:0], 8'h00});
        OpAddi: acc_d = acc_q + imm_ext;
        OpSubi: acc_d = acc_q - imm_ext;
        OpAndi: acc_d = acc_q & imm_ext;
        OpOri:  acc_d = acc_q | imm_ext;
        OpXori: acc_d = acc_q ^ imm_ext;
        // Shift amounts at or past the width naturally yield zero.
        OpShl:  acc_d = acc_q << sh;
        OpShr:  acc_d = acc_q >> sh;
        OpSt:   reg_we = 1'b1;
        OpLd:   acc_d = reg_rd;
        OpAddr: acc_d = acc_q + reg_rd;
        OpSubr: acc_d = acc_q - reg_rd;
        OpOut: begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        OpHalt: begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
          halt_d      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State update with synchronous reset overriding everything, including halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halt_q      <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halt_q      <= halt_d;
      if (reg_we) regs_q[r] <= acc_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed programs checked through the OUT/HALT port.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [11:0] instruction;
  logic [11:0] out_data;
  logic        out_valid;
  logic        halt;

  int checks;
  int failures;

  alu #(
    .data_width       (12),
    .instruction_width(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halt       (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction across one rising edge, then settle past the edge.
  task automatic exec(input logic [11:0] instr);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [11:0] exp_data);
    check({tag, "_valid"}, 12'(out_valid), 12'h001);
    check({tag, "_data"}, out_data, exp_data);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    instruction = 12'hFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_data", out_data, 12'h000);
    check("rst_valid", 12'(out_valid), 12'h000);
    check("rst_halt", 12'(halt), 12'h000);
    rst = 1'b0;

    // Basic load and emit, then the pulse drops while data holds.
    exec(12'h148); check("ldi_no_valid", 12'(out_valid), 12'h000);
    exec(12'hE00); check_out("out_48", 12'h048);
    exec(12'h000);
    check("nop_valid", 12'(out_valid), 12'h000);
    check("nop_hold", out_data, 12'h048);

    // LDH, ADDI and wrap-around arithmetic.
    exec(12'h1FF); exec(12'h20A); exec(12'h301); exec(12'hE00); check_out("ldh_add", 12'hB00);
    exec(12'h20F); exec(12'h1FF); exec(12'h20F); exec(12'h301); exec(12'hE00);
    check_out("add_wrap", 12'h000);
    exec(12'h401); exec(12'hE00); check_out("sub_wrap", 12'hFFF);

    // Register file operations.
    exec(12'h121);
    check("ldi_valid_low", 12'(out_valid), 12'h000);
    exec(12'hA02); exec(12'h110); exec(12'hC02); exec(12'hE00); check_out("addr", 12'h031);
    exec(12'hD02); exec(12'hE00); check_out("subr", 12'h010);
    exec(12'hB02); exec(12'hE00); check_out("ld", 12'h021);

    // Shifts and XOR, including a shift by the full width.
    exec(12'h10F); exec(12'h804); exec(12'hE00); check_out("shl", 12'h0F0);
    exec(12'h7FF); exec(12'hE00); check_out("xori", 12'h00F);
    exec(12'h90C); exec(12'hE00); check_out("shr12", 12'h000);

    // AND/OR with a back-to-back OUT pair.
    exec(12'h13C); exec(12'h50F); exec(12'h6A0); exec(12'hE00); check_out("andor", 12'h0AC);
    exec(12'hE00); check_out("out_b2b", 12'h0AC);
    check("pre_halt", 12'(halt), 12'h000);

    // Stash a register value, then HALT and confirm everything freezes.
    exec(12'h177); exec(12'hA02);
    exec(12'h141); exec(12'hF00);
    check_out("halt_pulse", 12'h041);
    check("halt_set", 12'(halt), 12'h001);
    exec(12'hE00);
    check("halted_out_valid", 12'(out_valid), 12'h000);
    check("halted_data", out_data, 12'h041);
    exec(12'h155); exec(12'hE00);
    check("halted_ldi_valid", 12'(out_valid), 12'h000);
    check("halted_ldi_data", out_data, 12'h041);
    check("halt_sticky", 12'(halt), 12'h001);

    // Reset out of halt clears registers and restarts execution.
    rst = 1'b1; instruction = 12'hE00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_data", out_data, 12'h000);
    check("rst2_valid", 12'(out_valid), 12'h000);
    check("rst2_halt", 12'(halt), 12'h000);
    exec(12'hB02); exec(12'hE00); check_out("r2_cleared", 12'h000);
    exec(12'h133); exec(12'hE00); check_out("restart", 12'h033);

    // Mid-program reset.
    exec(12'h105); exec(12'hA01); exec(12'hE00); check_out("pre_mid", 12'h005);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exec(12'hB01); exec(12'hE00); check_out("mid_rst_r1", 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
